mult_div_sequencer: RTL

- Iterative multi-cycle engine for MULT and DIV, driven by the multicycle control FSM's MultControl/DivControl pulses.
- Performs a signed 32x32 radix-2 Booth multiply or a signed restoring divide, one bit per clock.
- Owns and drives the Hi/Lo result registers.
- Reports busy/done/divide-by-zero back to the control FSM, which stalls until done.

---
 rtl/mult_div_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_sequencer.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) engine, one bit per clock.
// Owns the Hi/Lo result registers and reports busy/done/div_zero to the control FSM.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} seqState_t;

  seqState_t        stateReg, stateNext;
  logic [CW-1:0]    cntReg, cntNext;
  // Accumulator / partial remainder carries one extra bit so the most
  // negative multiplicand and the shifted remainder never overflow.
  logic [WIDTH:0]   accReg, accNext;
  logic [WIDTH-1:0] qReg, qNext;
  logic             qm1Reg, qm1Next;
  logic [WIDTH-1:0] mcandReg, mcandNext;
  logic             isDivReg, isDivNext;
  logic             negQuoReg, negQuoNext;
  logic             negRemReg, negRemNext;
  logic             divZeroReg, divZeroNext;
  logic [WIDTH-1:0] hiReg, hiNext;
  logic [WIDTH-1:0] loReg, loNext;

  logic [WIDTH:0]   boothRes;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH-1:0] absA, absB;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      cntReg     <= '0;
      accReg     <= '0;
      qReg       <= '0;
      qm1Reg     <= 1'b0;
      mcandReg   <= '0;
      isDivReg   <= 1'b0;
      negQuoReg  <= 1'b0;
      negRemReg  <= 1'b0;
      divZeroReg <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
    end else begin
      stateReg   <= stateNext;
      cntReg     <= cntNext;
      accReg     <= accNext;
      qReg       <= qNext;
      qm1Reg     <= qm1Next;
      mcandReg   <= mcandNext;
      isDivReg   <= isDivNext;
      negQuoReg  <= negQuoNext;
      negRemReg  <= negRemNext;
      divZeroReg <= divZeroNext;
      hiReg      <= hiNext;
      loReg      <= loNext;
    end
  end

  always_comb begin
    absA = op_a[WIDTH-1] ? -op_a : op_a;
    absB = op_b[WIDTH-1] ? -op_b : op_b;

    // Booth step selects add/subtract of the multiplicand from {q0, q-1}.
    case ({qReg[0], qm1Reg})
      2'b01:   boothRes = accReg + {mcandReg[WIDTH-1], mcandReg};
      2'b10:   boothRes = accReg - {mcandReg[WIDTH-1], mcandReg};
      default: boothRes = accReg;
    endcase

    divShift = {accReg[WIDTH-1:0], qReg[WIDTH-1]};
    divTrial = divShift - {1'b0, mcandReg};
  end

  always_comb begin
    stateNext   = stateReg;
    cntNext     = cntReg;
    accNext     = accReg;
    qNext       = qReg;
    qm1Next     = qm1Reg;
    mcandNext   = mcandReg;
    isDivNext   = isDivReg;
    negQuoNext  = negQuoReg;
    negRemNext  = negRemReg;
    divZeroNext = divZeroReg;
    hiNext      = hiReg;
    loNext      = loReg;

    case (stateReg)
      IDLE: begin
        divZeroNext = 1'b0;
        cntNext     = '0;
        if (mult_start) begin
          accNext   = '0;
          qNext     = op_b;
          qm1Next   = 1'b0;
          mcandNext = op_a;
          isDivNext = 1'b0;
          stateNext = MULT;
        end else if (div_start) begin
          if (op_b == '0) begin
            divZeroNext = 1'b1;
            stateNext   = DONE;
          end else begin
            accNext    = '0;
            qNext      = absA;
            qm1Next    = 1'b0;
            mcandNext  = absB;
            isDivNext  = 1'b1;
            negQuoNext = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            negRemNext = op_a[WIDTH-1];
            stateNext  = DIV;
          end
        end
      end

      MULT: begin
        accNext = {boothRes[WIDTH], boothRes[WIDTH:1]};
        qNext   = {boothRes[0], qReg[WIDTH-1:1]};
        qm1Next = qReg[0];
        cntNext = cntReg + 1'b1;
        if (cntReg == CW'(WIDTH - 1)) stateNext = FIX;
      end

      DIV: begin
        if (divTrial[WIDTH]) begin
          accNext = divShift;
          qNext   = {qReg[WIDTH-2:0], 1'b0};
        end else begin
          accNext = divTrial;
          qNext   = {qReg[WIDTH-2:0], 1'b1};
        end
        cntNext = cntReg + 1'b1;
        if (cntReg == CW'(WIDTH - 1)) stateNext = FIX;
      end

      FIX: begin
        if (isDivReg) begin
          loNext = negQuoReg ? -qReg : qReg;
          hiNext = negRemReg ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0];
        end else begin
          hiNext = accReg[WIDTH-1:0];
          loNext = qReg;
        end
        stateNext = DONE;
      end

      DONE: stateNext = IDLE;

      default: stateNext = IDLE;
    endcase
  end

  assign busy     = (stateReg == MULT) || (stateReg == DIV) || (stateReg == FIX);
  assign done     = (stateReg == DONE);
  assign div_zero = (stateReg == DONE) && divZeroReg;
  assign hi_out   = hiReg;
  assign lo_out   = loReg;

endmodule
